// File: rtl/pong_pkg.sv
// Shared PS/2 set-2 scan codes and the key decoder state type for the pong game.
// Latency: none (constants, types and one pure helper function).
// Backpressure: none.
package pong_pkg;

    // Game keys. UP and DOWN arrive behind the E0 extension prefix.
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_P      = 8'h4D;

    // Protocol bytes.
    localparam logic [7:0] SC_E0     = 8'hE0;  // extended-code prefix
    localparam logic [7:0] SC_F0     = 8'hF0;  // break (key release) prefix
    localparam logic [7:0] SC_AA     = 8'hAA;  // self-test passed
    localparam logic [7:0] SC_FA     = 8'hFA;  // command acknowledge
    localparam logic [7:0] SC_ERR_LO = 8'h00;  // key detection error / overrun
    localparam logic [7:0] SC_ERR_HI = 8'hFF;  // key detection error / overrun

    // Prefix decoder states: which prefixes have been seen for the byte to come.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    // One bit per tracked key: set on make, cleared on break.
    typedef struct packed {
        logic w;
        logic s;
        logic up;
        logic dn;
        logic r;
        logic p;
    } held_t;

    // Keyboard error bytes invalidate everything we believe is held.
    function automatic logic is_error_code(input logic [7:0] code);
        return (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_key_watchdog.sv
// Stale-key watchdog: flags keys that have been held with no keyboard traffic for TIMEOUT_CYCLES.
// Latency: expire asserts while the idle count sits at TIMEOUT_CYCLES-1 and a key is held.
// Backpressure: none; accept restarts the count, otherwise it saturates until the next byte.
//
// Ports:
//   CLOCK_50  system clock          rst_n     async active-low reset
//   accept    a byte was taken      any_held  at least one held bit set
//   expire    clear held bits this cycle
module ps2_key_watchdog #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic accept,
    input  logic any_held,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // Held bits only change on an accepted byte, which also restarts the
    // count, so this fires at most once per silent period.
    assign expire = (idle_cnt == LAST) && any_held;

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns PS/2 set-2 scan bytes into held-key paddle requests, a game-reset pulse and a pause level.
// Latency: outputs update on the clock edge that accepts a byte (one cycle after the scan_ready rise).
// Backpressure: none; one byte is taken per rising edge of scan_ready, a level held high is not re-read.
//
// Ports:
//   CLOCK_50                50 MHz system clock
//   rst_n                   asynchronous active-low reset
//   scan_code[7:0]          scan byte, valid while scan_ready is high
//   scan_ready              byte-available strobe (level, may span several cycles)
//   paddleL_up/paddleL_dn   left paddle requests (W / S)
//   paddleR_up/paddleR_dn   right paddle requests (E0 75 / E0 72)
//   reset_req               one-cycle pulse on a fresh R press
//   paused                  pause level, toggled by a fresh P press
//
// Build option: define KEY_TIMEOUT_EN to add the stale-key watchdog
// (ps2_key_watchdog, period TIMEOUT_CYCLES), which drops all held keys
// after a silent period so a lost break code cannot leave a paddle moving.
module ps2_key_tracker
    import pong_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       paddleL_up,
    output logic       paddleL_dn,
    output logic       paddleR_up,
    output logic       paddleR_dn,
    output logic       reset_req,
    output logic       paused
);

    logic       scan_ready_q;
    logic       accept;
    logic       key_make;
    logic       ext_code;
    logic       any_held;
    logic       wd_expire;
    logic       r_pulse;
    logic       p_toggle;
    kbd_state_t state;
    kbd_state_t state_nxt;
    held_t      held;
    held_t      held_nxt;

    // Edge-detect the strobe so a long scan_ready pulse is a single byte.
    assign accept   = scan_ready & ~scan_ready_q;

    // Without an F0 prefix the byte is a press; E0 selects the extended table.
    assign key_make = (state == IDLE) || (state == EXT);
    assign ext_code = (state == EXT)  || (state == EXT_BRK);
    assign any_held = |held;

    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        r_pulse   = 1'b0;
        p_toggle  = 1'b0;

        if (accept) begin
            // Anything that is not a prefix finishes the sequence.
            state_nxt = IDLE;

            if (is_error_code(scan_code)) begin
                held_nxt = '0;
            end else if ((scan_code == SC_E0) && (state != EXT_BRK)) begin
                // A repeated E0 keeps the extension; E0 after F0 joins it.
                state_nxt = (state == BRK) ? EXT_BRK : EXT;
            end else if ((scan_code == SC_F0) && key_make) begin
                state_nxt = (state == EXT) ? EXT_BRK : BRK;
            end else if (ext_code) begin
                case (scan_code)
                    SC_UP:   held_nxt.up = key_make;
                    SC_DOWN: held_nxt.dn = key_make;
                    default: ;
                endcase
            end else begin
                case (scan_code)
                    SC_W: held_nxt.w = key_make;
                    SC_S: held_nxt.s = key_make;
                    SC_R: begin
                        // Typematic repeats re-send the make; only the first one acts.
                        held_nxt.r = key_make;
                        r_pulse    = key_make & ~held.r;
                    end
                    SC_P: begin
                        held_nxt.p = key_make;
                        p_toggle   = key_make & ~held.p;
                    end
                    SC_AA, SC_FA: ;  // status replies, not keys
                    default: ;
                endcase
            end
        end else if (wd_expire) begin
            held_nxt  = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            scan_ready_q <= 1'b0;
            state        <= IDLE;
            held         <= '0;
            paddleL_up   <= 1'b0;
            paddleL_dn   <= 1'b0;
            paddleR_up   <= 1'b0;
            paddleR_dn   <= 1'b0;
            reset_req    <= 1'b0;
            paused       <= 1'b0;
        end else begin
            scan_ready_q <= scan_ready;
            state        <= state_nxt;
            held         <= held_nxt;
            // Opposing requests on one paddle cancel rather than pick a winner.
            paddleL_up   <= held_nxt.w  & ~held_nxt.s;
            paddleL_dn   <= held_nxt.s  & ~held_nxt.w;
            paddleR_up   <= held_nxt.up & ~held_nxt.dn;
            paddleR_dn   <= held_nxt.dn & ~held_nxt.up;
            reset_req    <= r_pulse;
            // A game reset always comes back unpaused.
            if (r_pulse) begin
                paused <= 1'b0;
            end else if (p_toggle) begin
                paused <= ~paused;
            end
        end
    end

`ifdef KEY_TIMEOUT_EN
    ps2_key_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .accept   (accept),
        .any_held (any_held),
        .expire   (wd_expire)
    );
`else
    assign wd_expire = 1'b0;

    // The period only matters when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) & any_held;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    localparam int TMO = 16;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       paddleL_up, paddleL_dn, paddleR_up, paddleR_dn, reset_req, paused;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .paddleL_up (paddleL_up),
        .paddleL_dn (paddleL_dn),
        .paddleR_up (paddleR_up),
        .paddleR_dn (paddleR_dn),
        .reset_req  (reset_req),
        .paused     (paused)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // ---------------- behavioural model ----------------
    // Keys: 0 W, 1 S, 2 UP, 3 DOWN, 4 R, 5 P
    bit m_held [6];
    bit m_ext, m_brk;     // prefixes pending for the next byte
    bit m_rr, m_paused;
    bit m_prev;           // scan_ready as last presented
    int m_silent;         // cycles since the last accepted byte
    int rr_seen = 0;

    function automatic int key_of(input bit ext, input logic [7:0] b);
        if (!ext) begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1B) return 1;
            if (b == 8'h2D) return 4;
            if (b == 8'h4D) return 5;
        end else begin
            if (b == 8'h75) return 2;
            if (b == 8'h72) return 3;
        end
        return -1;
    endfunction

    task automatic model_clear_keys();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_keys();
        m_rr = 1'b0; m_paused = 1'b0; m_prev = 1'b0; m_silent = 0;
    endtask

    function automatic bit any_held();
        foreach (m_held[i]) if (m_held[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit acc, input logic [7:0] b);
        int k;
        m_rr = 1'b0;
        if (acc) begin
            m_silent = 0;
            if (b == 8'h00 || b == 8'hFF) begin
                model_clear_keys();
            end else if (b == 8'hE0 && !(m_ext && m_brk)) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0 && !m_brk) begin
                m_brk = 1'b1;
            end else begin
                k = key_of(m_ext, b);
                if (k >= 0) begin
                    if (!m_brk) begin
                        if (k == 4 && !m_held[4]) begin m_rr = 1'b1; m_paused = 1'b0; end
                        if (k == 5 && !m_held[5]) m_paused = !m_paused;
                        m_held[k] = 1'b1;
                    end else begin
                        m_held[k] = 1'b0;
                    end
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else begin
`ifdef KEY_TIMEOUT_EN
            if (m_silent < TMO) m_silent++;
            if (m_silent >= TMO && any_held()) model_clear_keys();
`endif
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCK_50) begin
        logic [5:0] e, a;
        if (chk_en) begin
            e = {m_held[0] && !m_held[1], m_held[1] && !m_held[0],
                 m_held[2] && !m_held[3], m_held[3] && !m_held[2], m_rr, m_paused};
            a = {paddleL_up, paddleL_dn, paddleR_up, paddleR_dn, reset_req, paused};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got %b expected %b (Lu Ld Ru Rd rr pa)", $time, a, e);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {2'b00, paddleL_up, paddleL_dn, paddleR_up, paddleR_dn, reset_req, paused};
    endfunction

    task automatic step(input logic rdy, input logic [7:0] code);
        bit acc;
        scan_ready = rdy;
        scan_code  = code;
        @(posedge CLOCK_50);
        acc    = rdy && !m_prev;
        m_prev = rdy;
        #1;
        model_step(acc, code);
        if (reset_req) rr_seen++;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
        step(1'b0, b);
    endtask

    task automatic do_reset();
        scan_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rr0;
        rst_n = 1'b1; scan_ready = 1'b0; scan_code = 8'h00;
        model_reset();
        #5;
        rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        check("reset_outputs", outs(), 8'h00);

        // W press, then release via F0
        check("w_before_accept", paddleL_up, 1'b0);
        step(1'b1, 8'h1D);
        check("w_make_latency", paddleL_up, 1'b1);
        step(1'b0, 8'h1D);
        send(8'hF0);
        check("w_held_after_f0", paddleL_up, 1'b1);
        send(8'h1D);
        check("w_break", paddleL_up, 1'b0);

        // Right paddle up plus left down, then left conflict
        send(8'hE0); send(8'h75); send(8'h1B);
        check("r_up_and_l_dn", {paddleR_up, paddleL_dn}, 8'h03);
        send(8'h1D);
        check("left_conflict", {paddleL_up, paddleL_dn}, 8'h00);
        check("right_kept", paddleR_up, 1'b1);
        send(8'hF0); send(8'h1D);
        check("s_after_w_release", paddleL_dn, 1'b1);
        send(8'hF0); send(8'h1B);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("all_released", outs(), 8'h00);

        // Extended prefix hides base keys; status bytes change nothing
        send(8'hE0); send(8'h1D);
        check("ext_w_ignored", paddleL_up, 1'b0);
        send(8'h1D); send(8'hE0); send(8'hAA); send(8'hFA);
        check("status_bytes_no_change", paddleL_up, 1'b1);
        send(8'h1D);
        check("after_status_base_make", paddleL_up, 1'b1);
        send(8'hF0); send(8'h1D);

        // Typematic R gives one pulse; P toggles per fresh press
        rr0 = rr_seen;
        send(8'h2D); send(8'h2D); send(8'h2D);
        check("reset_pulse_count", 8'(rr_seen - rr0), 8'd1);
        send(8'hF0); send(8'h2D);
        send(8'h4D);
        check("pause_on", paused, 1'b1);
        send(8'hF0); send(8'h4D);
        check("pause_hold_on_release", paused, 1'b1);
        send(8'h4D);
        check("pause_off", paused, 1'b0);
        send(8'hF0); send(8'h4D);
        send(8'h4D); send(8'h4D);
        check("pause_typematic", paused, 1'b1);
        send(8'h2D);
        check("reset_clears_pause", paused, 1'b0);
        send(8'hF0); send(8'h2D); send(8'hF0); send(8'h4D);

        // Long scan_ready levels count once
        repeat (5) step(1'b1, 8'h1D);
        step(1'b0, 8'h1D);
        check("long_rdy_make", paddleL_up, 1'b1);
        repeat (5) step(1'b1, 8'hF0);
        step(1'b0, 8'hF0);
        send(8'h1D);
        check("long_rdy_single_f0", paddleL_up, 1'b0);

        // Reset discards a pending prefix
        send(8'hE0);
        do_reset();
        check("reset_mid_seq", outs(), 8'h00);
        send(8'h75);
        check("reset_discards_prefix", paddleR_up, 1'b0);

        // Error bytes drop held keys and the prefix
        send(8'h1D); send(8'hFF);
        check("ff_clears", outs(), 8'h00);
        send(8'hF0); send(8'h00); send(8'h1D);
        check("err_returns_idle", paddleL_up, 1'b1);
        send(8'hF0); send(8'h1D);

        // Stale-key watchdog
        step(1'b1, 8'h1D);
        check("wd_accept", paddleL_up, 1'b1);
        repeat (15) step(1'b0, 8'h1D);
        check("wd_before_limit", paddleL_up, 1'b1);
        step(1'b0, 8'h1D);
`ifdef KEY_TIMEOUT_EN
        check("wd_expired", paddleL_up, 1'b0);
`else
        check("no_wd_still_held", paddleL_up, 1'b1);
        repeat (30) step(1'b0, 8'h1D);
        check("no_wd_long_silence", paddleL_up, 1'b1);
`endif
        send(8'hF0); send(8'h1D);
        check("final_idle", outs(), 8'h00);

        step(1'b0, 8'h00);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100_000_000, sets the stale-key watchdog period in CLOCK_50 cycles (used only with KEY_TIMEOUT_EN).
REQ-002 CLOCK_50  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 scan_code  input  8  PS/2 set-2 byte from the keyboard interface; valid while scan_ready is high.
REQ-005 scan_ready  input  1  byte-available strobe; may stay high for more than one cycle.
REQ-006 paddleL_up / paddleL_dn  output  1 each  left paddle move requests (W / S).
REQ-007 paddleR_up / paddleR_dn  output  1 each  right paddle move requests (E0 75 / E0 72).
REQ-008 reset_req  output  1  one-cycle game-reset pulse (R, 0x2D).
REQ-009 paused  output  1  pause level, toggled by P (0x4D).

Function
REQ-010 A byte shall be accepted only on the cycle where scan_ready is high and its registered previous value is low; one byte per rising edge of scan_ready.
REQ-011 The decoder FSM shall have exactly the states IDLE, EXT, BRK and EXT_BRK.
REQ-012 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; BRK+E0->EXT_BRK; EXT+E0->EXT; any other accepted byte->IDLE after being applied.
REQ-013 A byte in IDLE/EXT shall be a make and set the matching held bit; a byte in BRK/EXT_BRK shall be a break and clear it. Extended codes count only through EXT/EXT_BRK; non-extended codes only through IDLE/BRK.
REQ-014 Held-bit updates shall be visible on outputs on the cycle after the accepting edge (one-cycle latency from the scan_ready rise).
REQ-015 When both up and down are held for one paddle, both of that paddle's outputs shall be 0.
REQ-016 reset_req shall pulse for exactly one cycle on an R make only when R was not already held, so typematic repeats produce no pulse.
REQ-017 paused shall toggle on a P make only when P was not already held; reset_req shall force paused to 0 on the same edge.
REQ-018 Bytes 0x00 and 0xFF (keyboard error or overrun) shall clear all held bits and return the FSM to IDLE.
REQ-019 Bytes 0xAA and 0xFA, and unknown codes, shall change no held bit; the FSM still returns to IDLE.

Reset
REQ-020 On rst_n low, the FSM shall go to IDLE, all held bits, all outputs and the scan_ready history register shall go to 0, and the watchdog counter shall clear.
REQ-021 Reset asserted mid-sequence (after E0 or F0) shall discard the prefix; the first byte after reset is decoded from IDLE.

Configuration
REQ-022 With macro KEY_TIMEOUT_EN defined, a counter shall clear on every accepted byte and increment otherwise. On reaching TIMEOUT_CYCLES-1 with any held bit set, it shall clear all held bits (paused unchanged), return the FSM to IDLE, and saturate until the next byte.
REQ-023 Without KEY_TIMEOUT_EN, no counter shall exist and held bits change only per REQ-013/018.

Structure
REQ-024 Package pong_pkg shall hold the scan-code constants (W, S, UP, DOWN, R, P, E0, F0, AA, FA) and the FSM state enum.
REQ-025 The watchdog shall be sub-module ps2_key_watchdog, instantiated only under KEY_TIMEOUT_EN.

Verification
REQ-026 Bytes 1D, then F0 1D -> paddleL_up rises one cycle after the first rise, then falls after the 1D following F0.
REQ-027 Bytes E0 75, then 1B -> paddleR_up=1 and paddleL_dn=1. Then bytes 1D -> paddleL_up=0 and paddleL_dn=0 (conflict per REQ-015).
REQ-028 Bytes 2D, 2D, 2D (typematic) -> exactly one reset_req pulse. Bytes 4D, F0 4D, 4D -> paused goes 1, then 0.
REQ-029 scan_ready held high 5 cycles with 1D -> a single accept; bytes E0, then rst_n pulse, then 75 -> no paddleR output.
REQ-030 Bytes 1D, then FF -> all outputs 0. With KEY_TIMEOUT_EN and TIMEOUT_CYCLES=16: 1D, then silence -> paddleL_up clears 16 cycles after the accept.
